// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: parameter defaults, FSM state
// encoding and word-select channel values.
package i2s_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Bit counter width that can hold 0..slot_w-1.
  function automatic int cnt_width(input int slot_w);
    return (slot_w > 1) ? $clog2(slot_w) : 1;
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the external bclk/ws pair into the sys_clk domain and produces a
// one-cycle strobe on each bclk falling edge.
module i2s_edge_sync
  import i2s_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic bclk,
  input  logic ws,
  output logic ws_sync,
  output logic fall
);

  logic [2:0] bclk_q;
  logic [1:0] ws_q;
  logic       rise;

  assign fall = bclk_q[2] & ~bclk_q[1];
  assign rise = bclk_q[1] & ~bclk_q[2];

  // ws is re-sampled mid-bit (bclk rise) so the value seen at a fall never
  // depends on the ws-versus-bclk skew around that same falling edge.
  // NOTE: every flop here uses <= so each stage takes the pre-edge value of
  // the previous one; blocking assignments would collapse the chain.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      bclk_q  <= '0;
      ws_q    <= {2{WS_RIGHT}};
      ws_sync <= WS_RIGHT;
    end else begin
      bclk_q <= {bclk_q[1:0], bclk};
      ws_q   <= {ws_q[0], ws};
      if (rise) ws_sync <= ws_q[1];
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S slave transmitter: one-entry sample-pair buffer, frame FSM and MSB-first
// serializer. Define I2S_TX_MUTE_ON_UNDERRUN_EN to send silence on underrun
// instead of repeating the previous frame.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bclk,
  input  logic              ws,
  input  logic [DATA_W-1:0] tx_left_data,
  input  logic [DATA_W-1:0] tx_right_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sdata,
  output logic              underrun
);

  localparam int CNT_W = cnt_width(SLOT_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOT_W - 1);

  logic              ws_sync;
  logic              fall;
  logic              ws_prev;
  logic [1:0]        state;

  logic              buf_full;
  logic [DATA_W-1:0] buf_left;
  logic [DATA_W-1:0] buf_right;
  logic [DATA_W-1:0] act_left;
  logic [DATA_W-1:0] act_right;
  logic [DATA_W-1:0] frame_left;
  logic [DATA_W-1:0] frame_right;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt;

  logic              accept;
  logic              left_start;
  logic              right_start;

  i2s_edge_sync u_edge_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bclk    (bclk),
    .ws      (ws),
    .ws_sync (ws_sync),
    .fall    (fall)
  );

  assign tx_ready    = !buf_full;
  assign accept      = tx_valid && tx_ready;
  assign left_start  = fall && (ws_sync == WS_LEFT)  && (ws_prev == WS_RIGHT);
  assign right_start = fall && (ws_sync == WS_RIGHT) && (ws_prev == WS_LEFT)
                       && (state != ST_IDLE);
  assign shreg_nxt   = shreg << 1;

  // Samples that become active at the next left-slot start.
  // NOTE: every always_comb output gets a default first, so a path that does
  // not assign it cannot infer a latch.
  always_comb begin
    frame_left  = act_left;
    frame_right = act_right;
    if (buf_full) begin
      frame_left  = buf_left;
      frame_right = buf_right;
    end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
      frame_left  = '0;
      frame_right = '0;
`endif
    end
  end

  // Holding buffer. A transfer only happens while empty, so it never collides
  // with the left-slot start draining it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      buf_full  <= 1'b0;
      buf_left  <= '0;
      buf_right <= '0;
    end else if (accept) begin
      buf_full  <= 1'b1;
      buf_left  <= tx_left_data;
      buf_right <= tx_right_data;
    end else if (left_start && buf_full) begin
      buf_full  <= 1'b0;
    end
  end

  // Frame FSM and active sample registers.
  // NOTE: the active sample registers are reset as well: in repeat mode a
  // frame held from before reset would otherwise be replayed after it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= ST_IDLE;
      ws_prev   <= WS_RIGHT;
      act_left  <= '0;
      act_right <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall) ws_prev <= ws_sync;
      if (left_start) begin
        state     <= ST_LEFT;
        act_left  <= frame_left;
        act_right <= frame_right;
        underrun  <= !buf_full;
      end else if (right_start) begin
        state <= ST_RIGHT;
      end
    end
  end

  // Serializer: MSB at slot start, DATA_W bits total, then zero padding.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      sdata   <= 1'b0;
    end else if (left_start) begin
      shreg   <= frame_left;
      bit_cnt <= '0;
      sdata   <= frame_left[DATA_W-1];
    end else if (right_start) begin
      shreg   <= act_right;
      bit_cnt <= '0;
      sdata   <= act_right[DATA_W-1];
    end else if (fall && (state != ST_IDLE)) begin
      if (bit_cnt < LAST_DATA) begin
        shreg <= shreg_nxt;
        sdata <= shreg_nxt[DATA_W-1];
      end else begin
        sdata <= 1'b0;
      end
      if (bit_cnt != LAST_SLOT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: drives bclk/ws frames, feeds sample pairs
// through the handshake and compares sdata bit by bit against a scoreboard.
module tb_i2s_tx;

  localparam int DW = 24;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          sys_clk;
  logic          sys_rst;
  logic          bclk;
  logic          ws;
  logic [DW-1:0] tx_left_data;
  logic [DW-1:0] tx_right_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          sdata;
  logic          underrun;

  int total = 0;
  int bad   = 0;
  int ur_cnt = 0;
  int exp_ur = 0;

  pair_t stim_q[$];
  pair_t exp_q[$];

  // Expected-output model: current slot word and bit index since slot start.
  logic [DW-1:0] word  = '0;
  logic [DW-1:0] cur_l = '0;
  logic [DW-1:0] cur_r = '0;
  int            idx   = 0;
  bit            frame_on = 1'b0;

  i2s_tx #(.DATA_W(DW), .SLOT_W(32)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .bclk          (bclk),
    .ws            (ws),
    .tx_left_data  (tx_left_data),
    .tx_right_data (tx_right_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .sdata         (sdata),
    .underrun      (underrun)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    if (k < DW) return w[DW-1-k];
    return 1'b0;
  endfunction

  // Producer: presents queued pairs; a pair is logged as delivered on the
  // edge where valid and ready are both high.
  initial begin
    bit acc;
    acc = 1'b0;
    tx_valid = 1'b0;
    tx_left_data = '0;
    tx_right_data = '0;
    forever begin
      @(negedge sys_clk);
      if (acc) check("ready_fall", tx_ready, 1'b0);
      acc = 1'b0;
      if (sys_rst === 1'b1 && stim_q.size() > 0) begin
        tx_left_data  = stim_q[0].l;
        tx_right_data = stim_q[0].r;
        tx_valid      = 1'b1;
        if (tx_ready) begin
          exp_q.push_back(stim_q.pop_front());
          acc = 1'b1;
        end
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (underrun === 1'b1) ur_cnt++;
    end
  end

  // One slot of n bclk periods with ws = ws_val; optional reset assert or
  // release right after the rising edge of bit rst_on / rst_off.
  task automatic run_slot(input logic ws_val, input int n, input int rst_on, input int rst_off);
    logic  toggled;
    logic  prev_bit;
    logic  ur_now;
    pair_t p;
    toggled = 1'b0;
    for (int i = 0; i < n; i++) begin
      bclk = 1'b0;
      if (i == 0) begin
        toggled = (ws != ws_val);
        ws = ws_val;
      end
      if (i == 1 && toggled && ws_val == 1'b0) begin
        prev_bit = exp_bit(word, idx);
        check("ready_pre", tx_ready, exp_q.size() == 0);
        ur_now = (exp_q.size() == 0);
        if (!ur_now) begin
          p = exp_q.pop_front();
          cur_l = p.l;
          cur_r = p.r;
        end else begin
          exp_ur++;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          cur_l = '0;
          cur_r = '0;
`endif
        end
        frame_on = 1'b1;
        word = cur_l;
        idx = 0;
        #17;
        check("lat_hold", sdata, prev_bit);
        #10;
        check("lat_msb", sdata, cur_l[DW-1]);
        check("ur_align", underrun, ur_now);
        #73;
      end else begin
        if (i == 1 && toggled && frame_on) begin
          word = cur_r;
          idx = 0;
        end else begin
          idx++;
        end
        #100;
      end
      bclk = 1'b1;
      check("sdata", sdata, exp_bit(word, idx));
      if (i == rst_on) begin
        sys_rst = 1'b0;
        #1;
        check("rst_sdata", sdata, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        stim_q.delete();
        exp_q.delete();
        cur_l = '0;
        cur_r = '0;
        word = '0;
        frame_on = 1'b0;
        #99;
      end else begin
        if (i == rst_off) sys_rst = 1'b1;
        #100;
      end
    end
  endtask

  initial begin
    sys_rst = 1'b0;
    bclk = 1'b1;
    ws = 1'b1;
    #20;
    check("reset_sdata", sdata, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_underrun", underrun, 1'b0);
    #30;
    sys_rst = 1'b1;
    #53;

    // ws held high after reset: stays idle and silent
    run_slot(1'b1, 32, -1, -1);
    stim_q.push_back('{l: 24'hA5C3F1, r: 24'h3C0F81});
    run_slot(1'b1, 32, -1, -1);
    check("underrun_idle", ur_cnt, exp_ur);

    // frame 1: pushed pair; frame 2: no pair -> underrun
    run_slot(1'b0, 32, -1, -1);
    check("underrun_f1", ur_cnt, exp_ur);
    run_slot(1'b1, 32, -1, -1);
    run_slot(1'b0, 32, -1, -1);
    check("underrun_f2", ur_cnt, exp_ur);

    // valid held high across three pairs, one consumed per frame
    stim_q.push_back('{l: 24'h123456, r: 24'h800001});
    stim_q.push_back('{l: 24'h0F0F0F, r: 24'hF0F0F0});
    stim_q.push_back('{l: 24'h7FFFFF, r: 24'h000001});
    run_slot(1'b1, 32, -1, -1);
    for (int f = 0; f < 3; f++) begin
      run_slot(1'b0, 32, -1, -1);
      check("underrun_stream", ur_cnt, exp_ur);
      if (f == 2) stim_q.push_back('{l: 24'hC0FFEE, r: 24'hBADA55});
      run_slot(1'b1, 32, -1, -1);
    end

    // reset mid-left after bit 10 with a pair waiting in the buffer
    stim_q.push_back('{l: 24'h55AA55, r: 24'hAA55AA});
    run_slot(1'b0, 32, 11, -1);
    check("underrun_rst", ur_cnt, exp_ur);
    run_slot(1'b1, 32, -1, 5);
    run_slot(1'b0, 32, -1, -1);
    check("underrun_post_rst", ur_cnt, exp_ur);

    // short 16-bclk left slot, then a 40-bclk left slot with underrun
    stim_q.push_back('{l: 24'hFFFFFF, r: 24'h3C0F81});
    run_slot(1'b1, 32, -1, -1);
    run_slot(1'b0, 16, -1, -1);
    check("underrun_short", ur_cnt, exp_ur);
    run_slot(1'b1, 32, -1, -1);
    run_slot(1'b0, 40, -1, -1);
    check("underrun_long", ur_cnt, exp_ur);
    run_slot(1'b1, 32, -1, -1);
    run_slot(1'b0, 2, -1, -1);
    check("underrun_final", ur_cnt, exp_ur);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
